// File: rtl/sodor_imem_responder.sv
// sodor_imem_responder
//   Responder end of the Sodor instruction-fetch port. Fetch requests are
//   decoded against a word-addressed text memory based at ADDR_BASE. Each
//   result travels through a LATENCY-stage pipeline into an in-order response
//   queue. A backdoor port fills the memory.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   io_req_valid/ready    fetch request handshake
//   io_req_bits_addr      byte address of the fetch
//   io_resp_valid/ready   response handshake
//   io_resp_bits_data     instruction word (0 when err)
//   io_resp_bits_err      address out of the text range or misaligned
//   io_load_en/addr/data  backdoor word write into mem
//
// Handshake: a transfer happens on a rising edge where valid && ready. ready
// never depends on valid, and a producer holding valid keeps its payload
// stable until the transfer.
module sodor_imem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 600,
    parameter int          LATENCY     = 1,
    parameter int          RESP_DEPTH  = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           io_req_valid,
    output logic                           io_req_ready,
    input  logic [31:0]                    io_req_bits_addr,
    output logic                           io_resp_valid,
    input  logic                           io_resp_ready,
    output logic [31:0]                    io_resp_bits_data,
    output logic                           io_resp_bits_err,
    input  logic                           io_load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] io_load_addr,
    input  logic [31:0]                    io_load_data
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = $clog2(RESP_DEPTH + 1);

    // Range limits are kept in 33 bits so the upper bound cannot wrap.
    localparam logic [32:0] BASE_X  = {1'b0, ADDR_BASE};
    localparam logic [32:0] LIMIT_X = BASE_X + 33'(4 * DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    // Decode
    logic [32:0]   addr_x;
    logic [32:0]   off_x;
    logic          req_err;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic          unused_off;

    assign addr_x     = {1'b0, io_req_bits_addr};
    assign off_x      = addr_x - BASE_X;
    assign req_err    = (addr_x < BASE_X) || (addr_x >= LIMIT_X) ||
                        (io_req_bits_addr[1:0] != 2'b00);
    assign word_idx   = off_x[AW+1:2];
    assign rd_word    = req_err ? 32'h0 : mem[word_idx];
    assign unused_off = &{1'b0, off_x[32:AW+2], off_x[1:0]};

    // Handshakes and credit
    logic          accept;
    logic          enq;
    logic          deq;
    logic [CW-1:0] occ;
    logic [CW-1:0] q_cnt;

    // occ counts requests in the pipeline plus entries in the queue, so a
    // queue slot is always reserved before a request is accepted.
    assign io_req_ready  = (occ < CW'(RESP_DEPTH));
    assign io_resp_valid = (q_cnt != '0);
    assign accept        = io_req_valid && io_req_ready;
    assign deq           = io_resp_valid && io_resp_ready;

    // Backdoor write. Not reset so the text survives a core reset. The read
    // for a same-edge fetch has already been taken from the old contents.
    always_ff @(posedge clock) begin
        if (io_load_en && (int'(io_load_addr) < DEPTH_WORDS)) begin
            mem[io_load_addr] <= io_load_data;
        end
    end

    // Fixed-latency pipeline: stage 0 captures the word at the accept edge,
    // the last stage feeds the queue.
    logic [LATENCY-1:0] pipe_v;
    logic [LATENCY-1:0] pipe_e;
    logic [31:0]        pipe_d [LATENCY];

    assign enq = pipe_v[LATENCY-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= accept;
            for (int k = 1; k < LATENCY; k++) begin
                pipe_v[k] <= pipe_v[k-1];
            end
        end
        pipe_d[0] <= rd_word;
        pipe_e[0] <= req_err;
        for (int k = 1; k < LATENCY; k++) begin
            pipe_d[k] <= pipe_d[k-1];
            pipe_e[k] <= pipe_e[k-1];
        end
    end

    // Response queue (circular buffer; depth need not be a power of two)
    logic [31:0]           q_data [RESP_DEPTH];
    logic [RESP_DEPTH-1:0] q_err;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(RESP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            q_cnt  <= '0;
            occ    <= '0;
        end else begin
            if (enq) begin
                q_data[wr_ptr] <= pipe_d[LATENCY-1];
                q_err[wr_ptr]  <= pipe_e[LATENCY-1];
                wr_ptr         <= next_ptr(wr_ptr);
            end
            if (deq) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            q_cnt <= q_cnt + CW'(enq) - CW'(deq);
            occ   <= occ + CW'(accept) - CW'(deq);
        end
    end

    // Head is read straight from storage, so it stays stable while stalled.
    assign io_resp_bits_data = io_resp_valid ? q_data[rd_ptr] : 32'h0;
    assign io_resp_bits_err  = io_resp_valid ? q_err[rd_ptr]  : 1'b0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(enq && !deq && (q_cnt == CW'(RESP_DEPTH))))
                else $error("response queue overflow");
        end
    end

endmodule

// File: tb/tb_sodor_imem_responder.sv
module tb_sodor_imem_responder;

    localparam logic [31:0] BASE = 32'h8000_0000;

    // Clock and reset
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // DUT A: default parameters
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        load_en = 1'b0;
    logic [9:0]  load_addr = '0;
    logic [31:0] load_data = '0;

    // DUT B: LATENCY=3, RESP_DEPTH=4
    logic        req_valid_3 = 1'b0;
    logic        req_ready_3;
    logic [31:0] req_addr_3 = '0;
    logic        resp_valid_3;
    logic        resp_ready_3 = 1'b1;
    logic [31:0] resp_data_3;
    logic        resp_err_3;
    logic        load_en_3 = 1'b0;
    logic [9:0]  load_addr_3 = '0;
    logic [31:0] load_data_3 = '0;

    sodor_imem_responder u_dut (
        .clock(clock), .reset(reset),
        .io_req_valid(req_valid), .io_req_ready(req_ready),
        .io_req_bits_addr(req_addr),
        .io_resp_valid(resp_valid), .io_resp_ready(resp_ready),
        .io_resp_bits_data(resp_data), .io_resp_bits_err(resp_err),
        .io_load_en(load_en), .io_load_addr(load_addr), .io_load_data(load_data)
    );

    sodor_imem_responder #(.LATENCY(3), .RESP_DEPTH(4)) u_dut3 (
        .clock(clock), .reset(reset),
        .io_req_valid(req_valid_3), .io_req_ready(req_ready_3),
        .io_req_bits_addr(req_addr_3),
        .io_resp_valid(resp_valid_3), .io_resp_ready(resp_ready_3),
        .io_resp_bits_data(resp_data_3), .io_resp_bits_err(resp_err_3),
        .io_load_en(load_en_3), .io_load_addr(load_addr_3), .io_load_data(load_data_3)
    );

    // Scoreboard: expected {err, data} in request order
    logic [32:0] exp_q[$];
    logic [32:0] exp3_q[$];
    int n_checks = 0;
    int n_errors = 0;
    int n_resp3  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs are stable from posedge+1 to the next posedge, so the negedge
    // sees exactly the handshake that the next edge will perform.
    always @(negedge clock) begin
        if (!reset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) check("unexpected_resp", {31'h0, resp_err, resp_data}, 64'h0);
            else check("resp", {31'h0, resp_err, resp_data}, {31'h0, exp_q.pop_front()});
        end
        if (!reset && resp_valid_3 && resp_ready_3) begin
            n_resp3++;
            if (exp3_q.size() == 0) check("unexpected_resp3", {31'h0, resp_err_3, resp_data_3}, 64'h0);
            else check("resp3", {31'h0, resp_err_3, resp_data_3}, {31'h0, exp3_q.pop_front()});
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] addr, input logic [32:0] expv);
        req_valid = 1'b1;
        req_addr  = addr;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                exp_q.push_back(expv);
                tick();
                return;
            end
            tick();
        end
        check("req_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check("drain", exp_q.size(), 0);
    endtask

    int acc_cyc;
    int resp_cyc;
    int issued;
    int cyc;

    initial begin
        // Reset, with backdoor loads performed while reset is held
        for (int i = 0; i < 16; i++) begin
            load_en_3   = 1'b1;
            load_addr_3 = 10'(i);
            load_data_3 = 32'(32'h1000_0000 + i);
            load_en     = (i < 4);
            case (i)
                0: begin load_addr = 10'd0;   load_data = 32'h0000_0093; end
                1: begin load_addr = 10'd1;   load_data = 32'h0010_0113; end
                2: begin load_addr = 10'd5;   load_data = 32'hAAAA_AAAA; end
                3: begin load_addr = 10'd599; load_data = 32'hDEAD_BEEF; end
                default: ;
            endcase
            tick();
        end
        load_en   = 1'b0;
        load_en_3 = 1'b0;
        reset     = 1'b0;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_resp_valid3", resp_valid_3, 0);

        // Basic back-to-back fetch
        req_valid = 1'b1;
        req_addr  = BASE;
        check("basic_rdy0", req_ready, 1);
        exp_q.push_back({1'b0, 32'h0000_0093});
        tick();
        check("basic_valid_c0", resp_valid, 0);
        check("basic_rdy1", req_ready, 1);
        req_addr = BASE + 32'd4;
        exp_q.push_back({1'b0, 32'h0010_0113});
        tick();
        req_valid = 1'b0;
        check("basic_valid_c1", resp_valid, 1);
        tick();
        check("basic_valid_c2", resp_valid, 1);
        tick();
        check("basic_valid_c3", resp_valid, 0);
        drain();

        // Range and alignment errors, plus the last valid word
        send(32'h7FFF_FFFC, {1'b1, 32'h0});
        send(32'h8000_0960, {1'b1, 32'h0});
        send(32'h8000_0002, {1'b1, 32'h0});
        send(32'h8000_095C, {1'b0, 32'hDEAD_BEEF});
        req_valid = 1'b0;
        drain();

        // Backpressure
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = BASE;
        check("bp_rdy0", req_ready, 1);
        exp_q.push_back({1'b0, 32'h0000_0093});
        tick();
        req_addr = BASE + 32'd4;
        check("bp_rdy1", req_ready, 1);
        exp_q.push_back({1'b0, 32'h0010_0113});
        tick();
        req_addr = BASE + 32'd8;
        check("bp_rdy_low", req_ready, 0);
        check("bp_valid", resp_valid, 1);
        check("bp_head", resp_data, 32'h0000_0093);
        tick();
        tick();
        check("bp_rdy_low2", req_ready, 0);
        check("bp_head_stable", resp_data, 32'h0000_0093);
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        tick();
        check("bp_rdy_back", req_ready, 1);
        check("bp_second", resp_data, 32'h0010_0113);
        tick();
        check("bp_empty", resp_valid, 0);
        drain();

        // Latency sweep on the LATENCY=3 instance
        acc_cyc = -1; resp_cyc = -1; issued = 0; cyc = 0;
        req_valid_3 = 1'b1;
        req_addr_3  = BASE;
        while ((issued < 16 || exp3_q.size() != 0) && cyc < 300) begin
            if (resp_valid_3 && resp_cyc < 0) resp_cyc = cyc;
            if (req_valid_3 && req_ready_3) begin
                if (acc_cyc < 0) acc_cyc = cyc;
                exp3_q.push_back({1'b0, 32'(32'h1000_0000 + issued)});
                issued++;
            end
            tick();
            cyc++;
            if (issued == 16) req_valid_3 = 1'b0;
            else req_addr_3 = 32'(BASE + 4 * issued);
        end
        check("lat3_done", exp3_q.size(), 0);
        // accept seen at sample a lands at edge a+1; +3 edges to the queue
        check("lat3_first", resp_cyc - acc_cyc, 4);
        check("lat3_count", n_resp3, 16);

        // Backdoor write colliding with a fetch of the same word
        load_en   = 1'b1;
        load_addr = 10'd5;
        load_data = 32'h5555_5555;
        req_valid = 1'b1;
        req_addr  = BASE + 32'h14;
        check("coll_rdy0", req_ready, 1);
        exp_q.push_back({1'b0, 32'hAAAA_AAAA});
        tick();
        load_en = 1'b0;
        check("coll_rdy1", req_ready, 1);
        exp_q.push_back({1'b0, 32'h5555_5555});
        tick();
        req_valid = 1'b0;
        drain();

        // Reset with two requests outstanding
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = BASE;
        tick();
        req_addr = BASE + 32'd4;
        tick();
        req_valid = 1'b0;
        check("mid_rdy_low", req_ready, 0);
        reset = 1'b1;
        exp_q.delete();
        tick();
        reset = 1'b0;
        check("mid_resp_valid", resp_valid, 0);
        check("mid_req_ready", req_ready, 1);
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_no_stale", resp_valid, 0);
        end
        send(BASE + 32'd4, {1'b0, 32'h0010_0113});
        send(BASE + 32'h14, {1'b0, 32'h5555_5555});
        req_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
